// File: rtl/demux_pkg.sv
// Shared constants and helpers for the buffered 1-to-2 demultiplexer.
// Optional cycle counters are enabled by defining DEMUX_CNT_EN.
package demux_pkg;
   localparam int CH0       = 0;
   localparam int CH1       = 1;
   localparam int NUM_CH    = 2;
   localparam int CNT_WIDTH = 8;

   // Pointer width for a power-of-2 FIFO depth (depth >= 2).
   function automatic int ptrw(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/demux_fifo_ch.sv
// Single-channel DEPTH-entry FIFO; head data is forced to 0 while empty.
// Caller guarantees push is only asserted when full is low.
module demux_fifo_ch
   import demux_pkg::*;
#(
   parameter int DATAWIDTH = 2,
   parameter int DEPTH     = 2,
   parameter int PTRW      = ptrw(DEPTH)
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 push,
   input  logic [DATAWIDTH-1:0] wdata,
   input  logic                 rd_ready,
   output logic [DATAWIDTH-1:0] rdata,
   output logic                 valid,
   output logic                 full
);
   logic [DATAWIDTH-1:0] mem [DEPTH];
   logic [PTRW-1:0]      wr_ptr, rd_ptr;
   logic [PTRW:0]        count;
   logic                 pop;

   assign valid = (count != '0);
   assign full  = (count == (PTRW+1)'(DEPTH));
   assign pop   = valid && rd_ready;
   assign rdata = valid ? mem[rd_ptr] : '0;

   // Storage is not reset; it is never visible while count is 0.
   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTRW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PTRW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/demux1x2_buf.sv
// Buffered 1-to-2 demux: steers each accepted beat into a per-channel FIFO.
// Define DEMUX_CNT_EN to add saturating accepted-beat counters cnt0/cnt1.
module demux1x2_buf
   import demux_pkg::*;
#(
   parameter int DATAWIDTH = 2,
   parameter int DEPTH     = 2,
   parameter int PTRW      = ptrw(DEPTH)
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATAWIDTH-1:0] a,
   input  logic                 sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DATAWIDTH-1:0] d0,
   output logic                 d0_valid,
   input  logic                 d0_ready,
   output logic [DATAWIDTH-1:0] d1,
   output logic                 d1_valid,
   input  logic                 d1_ready
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] cnt0,
   output logic [CNT_WIDTH-1:0] cnt1
`endif
);
   logic [NUM_CH-1:0]                push, full, valid, rdy;
   logic [NUM_CH-1:0][DATAWIDTH-1:0] rdata;

   // Ready depends only on sel and the registered occupancy, never on d*_ready.
   assign in_ready = !full[sel];
   assign rdy      = {d1_ready, d0_ready};

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign push[k] = in_valid && in_ready && (sel == 1'(k));
      demux_fifo_ch #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH), .PTRW(PTRW)) u_fifo (
         .Clk      (Clk),
         .Rst      (Rst),
         .push     (push[k]),
         .wdata    (a),
         .rd_ready (rdy[k]),
         .rdata    (rdata[k]),
         .valid    (valid[k]),
         .full     (full[k])
      );
   end

   assign d0       = rdata[CH0];
   assign d0_valid = valid[CH0];
   assign d1       = rdata[CH1];
   assign d1_valid = valid[CH1];

`ifdef DEMUX_CNT_EN
   logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_q;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
      always_ff @(posedge Clk or negedge Rst) begin
         if (!Rst)                          cnt_q[k] <= '0;
         else if (push[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
   end

   assign cnt0 = cnt_q[CH0];
   assign cnt1 = cnt_q[CH1];
`endif
endmodule

// File: tb/tb_demux1x2_buf.sv
// Self-checking bench for demux1x2_buf: directed vector table, reset corner,
// and randomized traffic against a queue-based reference model.
module tb_demux1x2_buf;
   localparam int DW    = 2;
   localparam int DEPTH = 2;

   logic          Clk = 1'b0;
   logic          Rst = 1'b0;
   logic [DW-1:0] a = '0;
   logic          sel = 1'b0, in_valid = 1'b0, d0_ready = 1'b0, d1_ready = 1'b0;
   logic          in_ready, d0_valid, d1_valid;
   logic [DW-1:0] d0, d1;
`ifdef DEMUX_CNT_EN
   logic [7:0]    cnt0, cnt1;
`endif

   int checks = 0;
   int errors = 0;

   demux1x2_buf #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
      .Clk(Clk), .Rst(Rst), .a(a), .sel(sel), .in_valid(in_valid),
      .in_ready(in_ready), .d0(d0), .d0_valid(d0_valid), .d0_ready(d0_ready),
      .d1(d1), .d1_valid(d1_valid), .d1_ready(d1_ready)
`ifdef DEMUX_CNT_EN
      , .cnt0(cnt0), .cnt1(cnt1)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic          iv, s, r0, r1;
      logic [DW-1:0] av;
      logic          e_ir, e_v0, e_v1;
      logic [DW-1:0] e_d0, e_d1;
   } vec_t;

   vec_t vt [$];

   function automatic vec_t mk(input logic iv, s, input logic [DW-1:0] av,
                               input logic r0, r1, ir, v0, input logic [DW-1:0] x0,
                               input logic v1, input logic [DW-1:0] x1);
      vec_t v;
      v.iv = iv; v.s = s; v.av = av; v.r0 = r0; v.r1 = r1;
      v.e_ir = ir; v.e_v0 = v0; v.e_d0 = x0; v.e_v1 = v1; v.e_d1 = x1;
      return v;
   endfunction

   // Reference model: per-channel queues
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   int            cm0, cm1;

   initial begin
      // Vectors: inputs applied, outputs expected before the following rising edge
      //          iv s  a     r0 r1 ir v0 d0    v1 d1
      // steering / latency
      vt.push_back(mk(1, 0, 2'b01, 0, 0, 1, 0, 2'b00, 0, 2'b00));
      vt.push_back(mk(1, 1, 2'b10, 0, 0, 1, 1, 2'b01, 0, 2'b00));
      vt.push_back(mk(0, 0, 2'b00, 0, 0, 1, 1, 2'b01, 1, 2'b10));
      vt.push_back(mk(0, 0, 2'b00, 1, 1, 1, 1, 2'b01, 1, 2'b10));
      vt.push_back(mk(0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 0, 2'b00));
      // full stall on ch0
      vt.push_back(mk(1, 0, 2'b11, 0, 0, 1, 0, 2'b00, 0, 2'b00));
      vt.push_back(mk(1, 0, 2'b10, 0, 0, 1, 1, 2'b11, 0, 2'b00));
      vt.push_back(mk(1, 0, 2'b01, 0, 0, 0, 1, 2'b11, 0, 2'b00));
      vt.push_back(mk(1, 0, 2'b01, 1, 0, 0, 1, 2'b11, 0, 2'b00));
      vt.push_back(mk(1, 0, 2'b01, 0, 0, 1, 1, 2'b10, 0, 2'b00));
      vt.push_back(mk(0, 0, 2'b00, 1, 0, 0, 1, 2'b10, 0, 2'b00));
      vt.push_back(mk(0, 0, 2'b00, 1, 0, 1, 1, 2'b01, 0, 2'b00));
      vt.push_back(mk(0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 0, 2'b00));
      // ch1 streaming across pointer wrap
      vt.push_back(mk(1, 1, 2'b00, 0, 1, 1, 0, 2'b00, 0, 2'b00));
      vt.push_back(mk(1, 1, 2'b01, 0, 1, 1, 0, 2'b00, 1, 2'b00));
      vt.push_back(mk(1, 1, 2'b10, 0, 1, 1, 0, 2'b00, 1, 2'b01));
      vt.push_back(mk(1, 1, 2'b11, 0, 1, 1, 0, 2'b00, 1, 2'b10));
      vt.push_back(mk(1, 1, 2'b00, 0, 1, 1, 0, 2'b00, 1, 2'b11));
      vt.push_back(mk(0, 1, 2'b00, 0, 1, 1, 0, 2'b00, 1, 2'b00));
      vt.push_back(mk(0, 1, 2'b00, 0, 0, 1, 0, 2'b00, 0, 2'b00));
      // independence: ch0 full, ch1 flowing
      vt.push_back(mk(1, 0, 2'b11, 0, 0, 1, 0, 2'b00, 0, 2'b00));
      vt.push_back(mk(1, 0, 2'b10, 0, 0, 1, 1, 2'b11, 0, 2'b00));
      vt.push_back(mk(1, 1, 2'b01, 0, 1, 1, 1, 2'b11, 0, 2'b00));
      vt.push_back(mk(1, 1, 2'b10, 0, 1, 1, 1, 2'b11, 1, 2'b01));
      vt.push_back(mk(1, 0, 2'b00, 0, 1, 0, 1, 2'b11, 1, 2'b10));
      vt.push_back(mk(0, 1, 2'b00, 0, 0, 1, 1, 2'b11, 0, 2'b00));

      #2;
      chk("reset_outputs", {in_ready, d0_valid, d0, d1_valid, d1}, {1'b1, 1'b0, 2'b00, 1'b0, 2'b00});
      @(negedge Clk); Rst = 1'b1;

      foreach (vt[i]) begin
         @(negedge Clk);
         in_valid = vt[i].iv; sel = vt[i].s; a = vt[i].av;
         d0_ready = vt[i].r0; d1_ready = vt[i].r1;
         #1;
         chk($sformatf("vec%0d", i), {in_ready, d0_valid, d0, d1_valid, d1},
             {vt[i].e_ir, vt[i].e_v0, vt[i].e_d0, vt[i].e_v1, vt[i].e_d1});
      end

      // Async reset mid-cycle with two beats held in ch0
      @(negedge Clk);
      in_valid = 1'b0; d0_ready = 1'b0; d1_ready = 1'b0; sel = 1'b0;
      #1 chk("pre_reset_full", {d0_valid, d0, in_ready}, {1'b1, 2'b11, 1'b0});
      #1 Rst = 1'b0;
      #1 chk("async_reset_drop", {d0_valid, d0}, {1'b0, 2'b00});
      @(negedge Clk); #2 Rst = 1'b1;
      #1 chk("post_reset_ir_sel0", {in_ready, d0_valid, d1_valid}, {1'b1, 1'b0, 1'b0});
      sel = 1'b1;
      #1 chk("post_reset_ir_sel1", {in_ready, d0_valid, d1_valid}, {1'b1, 1'b0, 1'b0});

      // Randomized traffic vs queue model (model is empty right after reset)
      cm0 = 0; cm1 = 0;
      for (int c = 0; c < 3000; c++) begin
         logic exp_ir, do_push, do_p0, do_p1;
         @(negedge Clk);
         in_valid = ($urandom_range(0, 3) != 0);
         sel      = 1'($urandom_range(0, 1));
         a        = DW'($urandom_range(0, 3));
         d0_ready = ($urandom_range(0, 2) == 0);
         d1_ready = ($urandom_range(0, 1) == 0);
         exp_ir   = sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
         #1;
         chk("rand", {in_ready, d0_valid, d0, d1_valid, d1},
             {exp_ir, q0.size() != 0, (q0.size() != 0) ? q0[0] : 2'b00,
              q1.size() != 0, (q1.size() != 0) ? q1[0] : 2'b00});
`ifdef DEMUX_CNT_EN
         chk("rand_cnt", {cnt0, cnt1}, {8'(cm0), 8'(cm1)});
`endif
         do_push = in_valid && exp_ir;
         do_p0   = d0_ready && (q0.size() != 0);
         do_p1   = d1_ready && (q1.size() != 0);
         @(posedge Clk);
         if (do_p0) void'(q0.pop_front());
         if (do_p1) void'(q1.pop_front());
         if (do_push) begin
            if (sel) begin q1.push_back(a); if (cm1 < 255) cm1++; end
            else     begin q0.push_back(a); if (cm0 < 255) cm0++; end
         end
      end

`ifdef DEMUX_CNT_EN
      // Saturation: 300 beats to ch0, 5 to ch1, both consumers always ready
      @(negedge Clk); Rst = 1'b0; in_valid = 1'b0;
      @(negedge Clk); Rst = 1'b1;
      d0_ready = 1'b1; d1_ready = 1'b1; in_valid = 1'b1; sel = 1'b0;
      for (int c = 0; c < 300; c++) @(negedge Clk);
      sel = 1'b1;
      for (int c = 0; c < 5; c++) @(negedge Clk);
      in_valid = 1'b0;
      @(negedge Clk);
      #1 chk("cnt_saturate", {cnt0, cnt1}, {8'd255, 8'd5});
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/demux1x2_buf.md
Name: demux1x2_buf

Overview:
- Buffered 1-to-2 demultiplexer: the routing counterpart of MUX2x1 in the datapath component library.
- Accepts one valid/ready input stream and steers each beat, by a per-beat select, into one of two per-channel FIFOs.
- Each FIFO drains independently on its own valid/ready output.
- Sits between a single producer and two consumers; preserves beat order per channel; fully registered outputs.

Parameters:
DATAWIDTH, 2, width of data beat (bits)
DEPTH, 2, entries per channel FIFO; power of 2, >= 2
PTRW, $clog2(DEPTH), pointer width (derived; not to be overridden)

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous active-low reset (0 = reset)
a  input  DATAWIDTH  input data beat
sel  input  1  destination channel for beat on a (0 -> d0, 1 -> d1)
in_valid  input  1  producer has beat on a/sel
in_ready  output  1  block accepts beat this cycle
d0  output  DATAWIDTH  channel 0 head data
d0_valid  output  1  channel 0 FIFO non-empty
d0_ready  input  1  channel 0 consumer takes head
d1  output  DATAWIDTH  channel 1 head data
d1_valid  output  1  channel 1 FIFO non-empty
d1_ready  input  1  channel 1 consumer takes head

Behaviour:
- Reset (Rst low, async): all pointers and occupancy counts = 0; d0_valid = d1_valid = 0; d0 = d1 = 0. Storage contents don't-care but never visible while valid = 0.
- Rst deasserts with no clock dependency on the assert edge; first push possible on the first rising edge with Rst high.
- in_ready = !full[sel]. This is combinational on sel and registered full flags only; there is no path from d*_ready.
- Push: at a rising edge with in_valid && in_ready, a is written into FIFO[sel] at wr_ptr[sel]; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop k: at a rising edge with dk_valid && dk_ready, rd_ptr[k] increments with the same wrap.
- dk = mem_k[rd_ptr[k]] whenever dk_valid = 1; dk = 0 when empty.
- Latency: a beat pushed at edge N is visible on dk/dk_valid after edge N (one cycle); no bypass.
- Per channel, count in 0..DEPTH: push-only +1, pop-only -1, push+pop same edge unchanged. full = (count == DEPTH); dk_valid = (count != 0).
- Full channel: in_ready = 0 for beats targeting it, even if dk_ready = 1 that cycle. The beat stalls; the other channel is unaffected only if the producer changes sel. The block never reorders or drops.
- Empty channel: dk_ready ignored; no pointer movement.
- Simultaneous push to ch0 and pop from ch1 (or any combination) are independent.
- in_valid = 0: sel and a ignored; no state change.
- dk_ready may toggle freely; dk and dk_valid are stable until popped.
- Reset mid-operation: all buffered beats are discarded, and valids drop immediately (asynchronous).

Optional Feature:
Macro DEMUX_CNT_EN.
- Defined: adds outputs cnt0 and cnt1 (each 8 bits). These are saturating counts of beats accepted into channel 0/1 since reset. They increment at the push edge, hold at 255, and reset to 0 asynchronously.
- Not defined: ports and counter logic absent; all other behaviour identical.

Decomposition:
- Shared package/include demux_pkg:
  - channel index constants CH0 = 0, CH1 = 1
  - CNT_WIDTH = 8
  - the PTRW derivation function/macro
- One natural sub-module, demux_fifo_ch:
  - single-channel DEPTH-entry FIFO with push/pop/count/full/valid
  - instantiated twice; the top holds only sel steering and in_ready mux.

Test Plan:
- Reset: Rst low mid-run with 2 beats buffered in ch0 -> d0_valid = 0 and d0 = 0 immediately; after release in_ready = 1 for both sel values.
- Steering/latency: push a = 2'b01 sel = 0, then a = 2'b10 sel = 1 on consecutive edges, d*_ready = 0 -> d0 = 01 valid one cycle after the first edge, d1 = 10 valid one cycle after the second, counts 1/1.
- Full stall: DEPTH = 2, d0_ready = 0, push 3 beats sel = 0 (11, 10, 01) -> third sees in_ready = 0 and stays pending. Raise d0_ready for one cycle -> 11 pops, 01 accepted next edge, then d0 order 10, 01.
- Wrap/order: DEPTH = 2, ch1 stream 00, 01, 10, 11, 00 with d1_ready = 1 continuously -> push+pop every edge, count stays 1, outputs in exact input order across pointer wrap.
- Independence: ch0 full with d0_ready = 0 while sel = 1 beats flow -> in_ready = 1 for sel = 1 and d1 drains normally; switching sel to 0 drops in_ready.
- With DEMUX_CNT_EN: 300 accepted beats to ch0, 5 to ch1 -> cnt0 = 255 (saturated), cnt1 = 5.
